// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared op codes, alu_op encodings and FSM states for alu_seq_unit
//
// Purpose: common definitions imported by alu_ctrl_decode and alu_seq_unit.
// Ports:   none (package).
// Macro:   ALU_MUL_EN adds the ST_MUL state; without it the MUL code is never produced.
package alu_seq_pkg;

  // 4-bit decoded operation codes; AND/OR/ADD/XOR/SUB keep the legacy ALU encoding
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  // M-extension encodings other than MUL: complete in one cycle with a zero result
  localparam logic [3:0] OP_ZERO = 4'b1111;

  // alu_op field from the main control unit
  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_ARITH  = 2'b10;
  localparam logic [1:0] ALUOP_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
`ifdef ALU_MUL_EN
    ,
    ST_MUL   = 2'd3
`endif
  } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational ALU-control decode to a 4-bit op code
//
// Purpose: maps alu_op/funct3/funct7/is_rtype onto the RV32I op set.
// Ports:   alu_op_i   - 2-bit class from main control
//          funct3_i   - instruction[14:12]
//          funct7_i   - instruction[31:25]
//          is_rtype_i - 1 = register-register, 0 = immediate
//          op_code_o  - decoded op code
// Macro:   ALU_MUL_EN decodes funct7=0000001 R-type ops (MUL or zero-result).
module alu_ctrl_decode
  import alu_seq_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  logic       is_rtype_i,
  output logic [3:0] op_code_o
);

  always_comb begin
    op_code_o = OP_ADD;
    case (alu_op_i)
      ALUOP_MEM:    op_code_o = OP_ADD;
      ALUOP_BRANCH: op_code_o = OP_SUB;
      ALUOP_ARITH: begin
        case (funct3_i)
          // ADDI has no SUB form, so funct7[5] only matters for R-type here
          3'b000: op_code_o = (is_rtype_i && funct7_i[5]) ? OP_SUB : OP_ADD;
          3'b001: op_code_o = OP_SLL;
          3'b010: op_code_o = OP_SLT;
          3'b011: op_code_o = OP_SLTU;
          3'b100: op_code_o = OP_XOR;
          3'b101: op_code_o = funct7_i[5] ? OP_SRA : OP_SRL;
          3'b110: op_code_o = OP_OR;
          3'b111: op_code_o = OP_AND;
          default: op_code_o = OP_ADD;
        endcase
`ifdef ALU_MUL_EN
        if (is_rtype_i && (funct7_i == 7'b0000001)) begin
          op_code_o = (funct3_i == 3'b000) ? OP_MUL : OP_ZERO;
        end
`endif
      end
      default: op_code_o = OP_ADD;
    endcase
  end

`ifndef ALU_MUL_EN
  logic unused_funct7;
  assign unused_funct7 = ^{funct7_i[6], funct7_i[4:0]};
`endif

endmodule

// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - sequential execute-stage ALU with valid/ready handshake
//
// Purpose: decodes and executes RV32I integer ops; logic/arith in one cycle,
//          shifts on an iterative shifter, optional iterative multiplier.
// Ports:   clk, rst           - clock, synchronous active-high reset
//          in_valid/in_ready  - operation handshake (in_ready combinational)
//          alu_op, funct3, funct7, is_rtype, op_a, op_b - operation fields
//          out_valid/out_ready - result handshake
//          result, zero, op_code - registered result, result==0, decoded op
// Macro:   ALU_MUL_EN compiles in the shift-add multiplier and its state.
module alu_seq_unit
  import alu_seq_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic            is_rtype,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [3:0]      op_code
);

  localparam int SHW = $clog2(XLEN);
  // counter must hold XLEN itself for the multiplier
  localparam int CW = SHW + 1;
  localparam logic [CW-1:0] STEP_C = CW'(SHIFT_STEP);

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic [3:0]      op_code_q, op_code_d;
  logic [XLEN-1:0] work_q, work_d;
  logic [CW-1:0]   cnt_q, cnt_d;
`ifdef ALU_MUL_EN
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] acc_nxt;
`endif

  logic [3:0]      dec_op;
  logic [SHW-1:0]  sh_amt;
  logic            accept;
  logic [XLEN-1:0] single;
  logic [CW-1:0]   step;
  logic [XLEN-1:0] shifted;

  alu_ctrl_decode u_decode (
    .alu_op_i   (alu_op),
    .funct3_i   (funct3),
    .funct7_i   (funct7),
    .is_rtype_i (is_rtype),
    .op_code_o  (dec_op)
  );

  assign sh_amt    = op_b[SHW-1:0];
  assign in_ready  = ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready)) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign op_code   = op_code_q;

  // One-cycle result; shifts land here only with a zero amount, so they pass op_a
  always_comb begin
    single = '0;
    case (dec_op)
      OP_AND:  single = op_a & op_b;
      OP_OR:   single = op_a | op_b;
      OP_ADD:  single = op_a + op_b;
      OP_XOR:  single = op_a ^ op_b;
      OP_SUB:  single = op_a - op_b;
      OP_SLT:  single = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: single = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      OP_SLL, OP_SRL, OP_SRA: single = op_a;
      default: single = '0;
    endcase
  end

  // Iterative shifter: at most SHIFT_STEP bits per cycle, fewer on the last step
  always_comb begin
    step    = (cnt_q > STEP_C) ? STEP_C : cnt_q;
    shifted = work_q;
    case (op_code_q)
      OP_SLL:  shifted = work_q << step;
      OP_SRL:  shifted = work_q >> step;
      default: shifted = $signed(work_q) >>> step;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    op_code_d = op_code_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
`ifdef ALU_MUL_EN
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    acc_nxt   = mplier_q[0] ? (acc_q + work_q) : acc_q;
`endif

    case (state_q)
      ST_IDLE: ;
      ST_SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q - step;
        // finish on the cycle that consumes the last bits, not one later
        if (cnt_q == step) begin
          state_d  = ST_DONE;
          result_d = shifted;
          zero_d   = (shifted == '0);
        end
      end
`ifdef ALU_MUL_EN
      ST_MUL: begin
        acc_d    = acc_nxt;
        work_d   = work_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = ST_DONE;
          result_d = acc_nxt;
          zero_d   = (acc_nxt == '0);
        end
      end
`endif
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new op can be taken from IDLE or in the same cycle DONE is drained
    if (accept) begin
      op_code_d = dec_op;
      work_d    = op_a;
      if (((dec_op == OP_SLL) || (dec_op == OP_SRL) || (dec_op == OP_SRA)) && (sh_amt != '0)) begin
        state_d = ST_SHIFT;
        cnt_d   = CW'(sh_amt);
      end
`ifdef ALU_MUL_EN
      else if (dec_op == OP_MUL) begin
        state_d  = ST_MUL;
        mplier_d = op_b;
        acc_d    = '0;
        cnt_d    = CW'(XLEN);
      end
`endif
      else begin
        state_d  = ST_DONE;
        result_d = single;
        zero_d   = (single == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      op_code_q <= OP_AND;
      work_q    <= '0;
      cnt_q     <= '0;
`ifdef ALU_MUL_EN
      mplier_q  <= '0;
      acc_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      op_code_q <= op_code_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
`ifdef ALU_MUL_EN
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb/tb_alu_seq_unit.sv - scoreboard bench for alu_seq_unit (directed + randomized)
module tb_alu_seq_unit;

  localparam int XLEN       = 32;
  localparam int SHIFT_STEP = 1;

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_XOR  = 4'b0011;
  localparam logic [3:0] C_SLL  = 4'b0100;
  localparam logic [3:0] C_SRL  = 4'b0101;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SRA  = 4'b0111;
  localparam logic [3:0] C_SLT  = 4'b1000;
  localparam logic [3:0] C_SLTU = 4'b1001;
  localparam logic [3:0] C_MUL  = 4'b1010;
  localparam logic [3:0] C_ZERO = 4'b1111;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  op;
    int          lat;
    int          e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        is_rtype;
  logic [31:0] op_a, op_b;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic        zero;
  logic [3:0]  op_code;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   rdy_rand = 1'b0;
  exp_t exp_q[$];

  alu_seq_unit #(.XLEN(XLEN), .SHIFT_STEP(SHIFT_STEP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .is_rtype(is_rtype),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .op_code(op_code)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic [3:0] op, input int lat);
    exp_t e;
    e.r = r; e.op = op; e.lat = lat; e.e = 0;
    return e;
  endfunction

  // Reference: straight from the RV32I semantics, latency from the shift/mul rules
  function automatic exp_t model(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic rt, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   s;
    s = int'(b[4:0]);
    e = mk(a + b, C_ADD, 0);
    if (aop == 2'b01) e = mk(a - b, C_SUB, 0);
    else if (aop != 2'b10) e = mk(a + b, C_ADD, 0);
`ifdef ALU_MUL_EN
    else if (rt && f7 == 7'h01) e = (f3 == 3'b000) ? mk(a * b, C_MUL, XLEN) : mk(32'h0, C_ZERO, 0);
`endif
    else begin
      case (f3)
        3'b000: e = (rt && f7[5]) ? mk(a - b, C_SUB, 0) : mk(a + b, C_ADD, 0);
        3'b001: e = mk(a << s, C_SLL, (s + SHIFT_STEP - 1) / SHIFT_STEP);
        3'b010: e = mk(($signed(a) < $signed(b)) ? 32'd1 : 32'd0, C_SLT, 0);
        3'b011: e = mk((a < b) ? 32'd1 : 32'd0, C_SLTU, 0);
        3'b100: e = mk(a ^ b, C_XOR, 0);
        3'b101: e = f7[5] ? mk($signed(a) >>> s, C_SRA, (s + SHIFT_STEP - 1) / SHIFT_STEP)
                          : mk(a >> s, C_SRL, (s + SHIFT_STEP - 1) / SHIFT_STEP);
        3'b110: e = mk(a | b, C_OR, 0);
        default: e = mk(a & b, C_AND, 0);
      endcase
    end
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
    if (rdy_rand) out_ready = ($urandom_range(0, 9) < 7);
  endtask

  // Offer an op (called at a negedge); push its expectation when accepted
  task automatic issue(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                       input logic rt, input logic [31:0] a, input logic [31:0] b,
                       input exp_t ex, output int waits);
    exp_t e;
    e = ex;
    in_valid = 1'b1; alu_op = aop; funct3 = f3; funct7 = f7; is_rtype = rt; op_a = a; op_b = b;
    waits = 0;
    #1;
    while (!in_ready && waits < 200) begin
      tick(); #1; waits++;
    end
    if (!in_ready) begin
      check("accept_timeout", {31'b0, in_ready}, 32'd1);
      in_valid = 1'b0;
    end else begin
      e.e = cyc + 1;
      exp_q.push_back(e);
      tick();
      in_valid = 1'b0;
      alu_op = 2'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
      is_rtype = 1'($urandom); op_a = $urandom; op_b = $urandom;
    end
  endtask

  task automatic issue_rand();
    logic [1:0]  aop;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        rt;
    logic [31:0] a, b;
    int          w;
    aop = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b10;
    f3  = 3'($urandom);
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    rt = 1'($urandom);
    a  = pick();
    b  = pick();
    issue(aop, f3, f7, rt, a, b, model(aop, f3, f7, rt, a, b), w);
  endtask

  initial begin : monitor
    exp_t e;
    bit   fresh;
    int   since;
    fresh = 1'b1;
    since = 0;
    forever begin
      @(negedge clk); #3;
      if (rst || !out_valid) begin
        fresh = 1'b1;
      end else begin
        if (fresh) begin
          since = cyc;
          fresh = 1'b0;
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_output: actual result %h required no output", result);
          end else begin
            e = exp_q.pop_front();
            check("result", result, e.r);
            check("zero", {31'b0, zero}, {31'b0, (e.r == 32'h0)});
            check("op_code", {28'b0, op_code}, {28'b0, e.op});
            check("latency", 32'(since - e.e), 32'(e.lat));
          end
          fresh = 1'b1;
        end
      end
    end
  end

  initial begin : driver
    int w;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = 2'b00; funct3 = 3'b000; funct7 = 7'h00; is_rtype = 1'b0; op_a = '0; op_b = '0;
    tick(); tick();
    #1;
    check("reset_in_ready", {31'b0, in_ready}, 32'd0);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("init_result", result, 32'h0);
    check("init_zero", {31'b0, zero}, 32'd0);
    check("init_op_code", {28'b0, op_code}, 32'd0);
    check("init_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    out_ready = 1'b1;

    // R-type SUB, I-type ADD, branch compare: back-to-back, one per cycle
    issue(2'b10, 3'b000, 7'h20, 1'b1, 32'd5, 32'd7, mk(32'hFFFF_FFFE, C_SUB, 0), w);
    issue(2'b10, 3'b000, 7'h20, 1'b0, 32'd5, 32'd7, mk(32'd12, C_ADD, 0), w);
    check("back_to_back_add", 32'(w), 32'd0);
    issue(2'b01, 3'($urandom), 7'($urandom), 1'($urandom), 32'h1234, 32'h1234, mk(32'h0, C_SUB, 0), w);
    check("back_to_back_branch", 32'(w), 32'd0);

    // SRAI by 31; a pending op must not be taken while shifting
    issue(2'b10, 3'b101, 7'h20, 1'b0, 32'h8000_0000, 32'd31, mk(32'hFFFF_FFFF, C_SRA, 31), w);
    in_valid = 1'b1; alu_op = 2'b10; funct3 = 3'b111; funct7 = 7'h00; is_rtype = 1'b1;
    op_a = 32'hF0F0_1234; op_b = 32'h0FF0_FFFF;
    w = 0;
    #1;
    while (!out_valid && w < 60) begin
      check("busy_in_ready", {31'b0, in_ready}, 32'd0);
      tick(); #1; w++;
    end
    issue(2'b10, 3'b111, 7'h00, 1'b1, 32'hF0F0_1234, 32'h0FF0_FFFF, mk(32'h00F0_1234, C_AND, 0), w);
    check("accept_after_shift", 32'(w), 32'd0);
    tick();

    // Backpressure: SLTU held for 5 cycles with a new op pending
    out_ready = 1'b0;
    issue(2'b10, 3'b011, 7'h00, 1'b1, 32'd1, 32'hFFFF_FFFF, mk(32'd1, C_SLTU, 0), w);
    in_valid = 1'b1; alu_op = 2'b10; funct3 = 3'b100; funct7 = 7'h00; is_rtype = 1'b1;
    op_a = 32'h0000_FFFF; op_b = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("hold_out_valid", {31'b0, out_valid}, 32'd1);
      check("hold_result", result, 32'd1);
      check("hold_op_code", {28'b0, op_code}, {28'b0, C_SLTU});
      check("hold_in_ready", {31'b0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    issue(2'b10, 3'b100, 7'h00, 1'b1, 32'h0000_FFFF, 32'h1234_5678, mk(32'h1234_A987, C_XOR, 0), w);
    check("accept_on_release", 32'(w), 32'd0);
    tick();

    // MUL encoding (ADD when the multiplier is not built)
`ifdef ALU_MUL_EN
    issue(2'b10, 3'b000, 7'h01, 1'b1, 32'hFFFF_FFFF, 32'd3, mk(32'hFFFF_FFFD, C_MUL, 32), w);
`else
    issue(2'b10, 3'b000, 7'h01, 1'b1, 32'hFFFF_FFFF, 32'd3, mk(32'd2, C_ADD, 0), w);
`endif
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      tick(); w++;
    end

    // Reset mid-operation aborts without producing a result
`ifdef ALU_MUL_EN
    issue(2'b10, 3'b000, 7'h01, 1'b1, 32'd7, 32'd9, mk(32'd63, C_MUL, 32), w);
`else
    issue(2'b10, 3'b101, 7'h00, 1'b1, 32'hF000_0000, 32'd31, mk(32'd1, C_SRL, 31), w);
`endif
    repeat (4) tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    #1;
    check("abort_in_ready_in_reset", {31'b0, in_ready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_result", result, 32'h0);
    check("abort_zero", {31'b0, zero}, 32'd0);
    check("abort_op_code", {28'b0, op_code}, 32'd0);
    check("abort_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    #1;
    check("abort_no_result", {31'b0, out_valid}, 32'd0);
    tick();

    // Randomized ops with random consumer backpressure and idle gaps
    rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      issue_rand();
    end

    rdy_rand = 1'b0;
    out_ready = 1'b1;
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      tick(); w++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
